// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - receive byte FIFO with status, overflow, threshold and optional timeout (UART_RX_FIFO_TIMEOUT_EN)
module uart_rx_fifo #(
    parameter int DEPTH         = 16,
    parameter int LVL_W         = $clog2(DEPTH) + 1,
    parameter int TIMEOUT_TICKS = 64
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             wr_valid_i,
    input  logic [7:0]       wr_data_i,
    input  logic             wr_err_i,
    input  logic             rd_en_i,
    output logic [7:0]       rd_data_o,
    output logic             rd_err_o,
    output logic             empty_o,
    output logic             full_o,
    output logic [LVL_W-1:0] level_o,
    input  logic [LVL_W-1:0] threshold_i,
    input  logic             flush_i,
    input  logic             ovf_clr_i,
    output logic             ovf_o,
    output logic             thr_int_o,
    input  logic             trigger_i,
    output logic             timeout_int_o
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    logic [8:0]       mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic [LVL_W-1:0] level;
    logic [8:0]       head;
    logic             push;
    logic             pop;
    logic             ovf_set;

    // Status derives only from the registered level, never from the strobes.
    assign empty_o = (level == '0);
    assign full_o  = (level == FULL_LVL);
    assign level_o = level;

    // A pop in the same cycle frees a slot, so a full FIFO still accepts the byte.
    assign push    = wr_valid_i && (!full_o || rd_en_i);
    assign pop     = rd_en_i && !empty_o;
    assign ovf_set = wr_valid_i && full_o && !rd_en_i;

    // Show-ahead head entry; forced to zero when nothing is stored.
    assign head      = mem[rd_ptr];
    assign rd_data_o = empty_o ? 8'h00 : head[7:0];
    assign rd_err_o  = empty_o ? 1'b0  : head[8];

    // Entry storage: {err, data} written at the write pointer.
    always_ff @(posedge clk_i) begin
        if (push && !flush_i) begin
            mem[wr_ptr] <= {wr_err_i, wr_data_i};
        end
    end

    // Pointers and level; flush discards any concurrent push or pop.
    always_ff @(posedge clk_i) begin
        if (!rst_i || flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (push && !pop) begin
                level <= level + LVL_W'(1);
            end else if (pop && !push) begin
                level <= level - LVL_W'(1);
            end
        end
    end

    // Sticky overflow; a new overflow beats a clear in the same cycle.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            ovf_o <= 1'b0;
        end else if (ovf_set) begin
            ovf_o <= 1'b1;
        end else if (ovf_clr_i) begin
            ovf_o <= 1'b0;
        end
    end

    // Level-threshold interrupt, registered from the current level.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            thr_int_o <= 1'b0;
        end else begin
            thr_int_o <= (threshold_i != '0) && (level >= threshold_i);
        end
    end

`ifdef UART_RX_FIFO_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [CW-1:0] TO_LIMIT = CW'(TIMEOUT_TICKS);

    logic [CW-1:0] to_cnt;

    // Count ticks of inactivity while data waits; saturate at the limit.
    always_ff @(posedge clk_i) begin
        if (!rst_i || push || pop || flush_i) begin
            to_cnt        <= '0;
            timeout_int_o <= 1'b0;
        end else if (empty_o) begin
            to_cnt <= '0;
        end else if (trigger_i && (to_cnt != TO_LIMIT)) begin
            to_cnt <= to_cnt + CW'(1);
            if (to_cnt + CW'(1) == TO_LIMIT) begin
                timeout_int_o <= 1'b1;
            end
        end
    end
`else
    logic unused_timeout;

    assign unused_timeout = trigger_i ^ (TIMEOUT_TICKS == 0);
    assign timeout_int_o  = 1'b0;
`endif

endmodule
